// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the ALU command sequencer and its environment:
// command push port, ALU drive/return, response handshake and status.
interface alu_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Command push side
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_a;
    logic [3:0]    cmd_b;
    logic [2:0]    cmd_sel;
    logic          cmd_use_acc;

    // Drive to and return from the combinational ALU
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [3:0]    alu_result;
    logic          alu_carry;
    logic          alu_zero;

    // Response handshake
    logic          rsp_valid;
    logic          rsp_ready;
    logic [3:0]    rsp_result;
    logic          rsp_carry;
    logic          rsp_zero;

    // Status
    logic [3:0]    acc;
    logic [CW-1:0] fifo_count;

    // Sequencer view
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc,
        input  alu_result, alu_carry, alu_zero,
        input  rsp_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero,
        output acc, fifo_count
    );

    // Environment view (command source, ALU, response sink)
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc,
        output alu_result, alu_carry, alu_zero,
        output rsp_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero,
        input  acc, fifo_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of a combinational 4-bit ALU, with a registered
// response stage and an accumulator usable as operand A by later commands.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Entry layout: {a[3:0], b[3:0], sel[2:0], use_acc}
    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          r_rsp_valid;
    logic [3:0]    r_rsp_result;
    logic          r_rsp_carry;
    logic          r_rsp_zero;
    logic [3:0]    r_acc;

    logic          w_cmd_ready;
    logic          w_push;
    logic          w_head_ok;
    logic          w_out_free;
    logic          w_pop;
    logic [11:0]   w_wr_entry;
    logic [11:0]   w_head;

    assign w_cmd_ready = (r_count < CW'(DEPTH));
    assign w_push      = bus.cmd_valid && w_cmd_ready;
    assign w_head_ok   = (r_count != '0);
    assign w_out_free  = !r_rsp_valid || bus.rsp_ready;
    assign w_pop       = w_head_ok && w_out_free;
    assign w_wr_entry  = {bus.cmd_a, bus.cmd_b, bus.cmd_sel, bus.cmd_use_acc};
    assign w_head      = r_mem[r_rd_ptr];

    // use_acc is resolved here at issue time, so a chained command always
    // sees the accumulator written by the command issued just before it.
    assign bus.alu_a   = !w_head_ok ? 4'h0 : (w_head[0] ? r_acc : w_head[11:8]);
    assign bus.alu_b   = !w_head_ok ? 4'h0 : w_head[7:4];
    assign bus.alu_sel = !w_head_ok ? 3'h0 : w_head[3:1];

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.acc        = r_acc;
    assign bus.fifo_count = r_count;

    // Command storage; contents need no reset since pointers/count gate use
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response register and accumulator capture the ALU output on issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 4'h0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_acc        <= 4'h0;
        end else if (w_pop) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= bus.alu_result;
            r_rsp_carry  <= bus.alu_carry;
            r_rsp_zero   <= bus.alu_zero;
            r_acc        <= bus.alu_result;
        end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a behavioural 4-bit ALU.
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    alu_cmd_sequencer_if #(.DEPTH(4)) bus ();

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: 5-bit result, bit 4 is the carry/borrow
    // 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL, 111 SHR
    logic [4:0] alu_full;
    always_comb begin
        alu_full = 5'h00;
        case (bus.alu_sel)
            3'b000: alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b001: alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'b010: alu_full = {1'b0, bus.alu_a & bus.alu_b};
            3'b011: alu_full = {1'b0, bus.alu_a | bus.alu_b};
            3'b100: alu_full = {1'b0, bus.alu_a ^ bus.alu_b};
            3'b101: alu_full = ~{1'b0, bus.alu_a};
            3'b110: alu_full = {bus.alu_a, 1'b0};
            default: alu_full = {2'b00, bus.alu_a[3:1]};
        endcase
        bus.alu_result = alu_full[3:0];
        bus.alu_carry  = alu_full[4];
        bus.alu_zero   = (alu_full[3:0] == 4'h0);
    end

    // Response monitor: a handshake happens on the edge following this sample
    logic [5:0] rsp_q [$];
    int         rsp_cyc_q [$];
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            rsp_q.push_back({bus.rsp_result, bus.rsp_carry, bus.rsp_zero});
            rsp_cyc_q.push_back(cyc);
        end
    end

    task automatic push_one(input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] sel, input logic ua);
        int t;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = sel; bus.cmd_use_acc = ua;
        bus.cmd_valid = 1'b1;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: cmd_ready stayed %b, required 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string name);
        for (int t = 0; t < 60 && rsp_q.size() < n; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_q.size() != n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d responses, required %0d", name, rsp_q.size(), n);
        end
    endtask

    task automatic idle_clear();
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rsp_q.delete();
        rsp_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
        bus.cmd_use_acc = 1'b0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd0 || bus.rsp_valid !== 1'b0 || bus.acc !== 4'h0 ||
            bus.rsp_result !== 4'h0 || bus.rsp_carry !== 1'b0 || bus.rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d valid=%b acc=%h res=%h c=%b z=%b, required all 0",
                     bus.fifo_count, bus.rsp_valid, bus.acc, bus.rsp_result, bus.rsp_carry, bus.rsp_zero);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", bus.cmd_ready);
        end
        // Mid-stream reset: one command in the response register, three queued
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) push_one(4'(i), 4'h1, 3'b000, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd3 || bus.rsp_valid !== 1'b1 || bus.acc !== 4'h2) begin
            n_fail++;
            $display("FAIL prereset_fill: count=%0d valid=%b acc=%h, required 3 1 2",
                     bus.fifo_count, bus.rsp_valid, bus.acc);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.fifo_count !== 3'd0 || bus.rsp_valid !== 1'b0 || bus.acc !== 4'h0) begin
            n_fail++;
            $display("FAIL midreset_state: count=%0d valid=%b acc=%h, required 0 0 0",
                     bus.fifo_count, bus.rsp_valid, bus.acc);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_cmd_ready: got %b, required 1", bus.cmd_ready);
        end
        rsp_q.delete(); rsp_cyc_q.delete();
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_q.size() != 0 || bus.rsp_valid !== 1'b0 || bus.acc !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_discard: responses=%0d valid=%b acc=%h, required 0 0 0",
                     rsp_q.size(), bus.rsp_valid, bus.acc);
        end
    endtask

    task automatic test_single_add();
        idle_clear();
        push_one(4'h9, 4'h8, 3'b000, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd1 || bus.alu_a !== 4'h9 || bus.alu_b !== 4'h8 ||
            bus.alu_sel !== 3'b000 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_queued: count=%0d a=%h b=%h sel=%0d valid=%b, required 1 9 8 0 0",
                     bus.fifo_count, bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h1 || bus.rsp_carry !== 1'b1 ||
            bus.rsp_zero !== 1'b0 || bus.acc !== 4'h1 || bus.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL add_rsp: v=%b r=%h c=%b z=%b acc=%h cnt=%0d, required 1 1 1 0 1 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.acc, bus.fifo_count);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 4'h1 || bus.alu_a !== 4'h0 ||
            bus.alu_b !== 4'h0 || bus.alu_sel !== 3'h0) begin
            n_fail++;
            $display("FAIL add_drain: v=%b r=%h a=%h b=%h sel=%0d, required 0 1 0 0 0",
                     bus.rsp_valid, bus.rsp_result, bus.alu_a, bus.alu_b, bus.alu_sel);
        end
        wait_rsp(1, "add");
    endtask

    task automatic test_acc_chain();
        logic [5:0] exp_rsp [3];
        exp_rsp[0] = {4'h7, 1'b0, 1'b0};
        exp_rsp[1] = {4'h9, 1'b0, 1'b0};
        exp_rsp[2] = {4'h0, 1'b0, 1'b1};
        idle_clear();
        push_one(4'h3, 4'h4, 3'b000, 1'b0);
        push_one(4'hF, 4'h2, 3'b000, 1'b1);
        push_one(4'hF, 4'h9, 3'b001, 1'b1);
        wait_rsp(3, "chain");
        for (int i = 0; i < 3 && i < rsp_q.size(); i++) begin
            n_checks++;
            if (rsp_q[i] !== exp_rsp[i]) begin
                n_fail++;
                $display("FAIL chain_rsp%0d: {res,c,z}=%h/%b/%b, required %h/%b/%b", i,
                         rsp_q[i][5:2], rsp_q[i][1], rsp_q[i][0],
                         exp_rsp[i][5:2], exp_rsp[i][1], exp_rsp[i][0]);
            end
        end
        n_checks++;
        if (bus.acc !== 4'h0) begin
            n_fail++; $display("FAIL chain_acc: got %h, required 0", bus.acc);
        end
    endtask

    task automatic test_flags();
        idle_clear();
        push_one(4'h3, 4'h5, 3'b001, 1'b0);
        push_one(4'hF, 4'h0, 3'b101, 1'b0);
        wait_rsp(2, "flags");
        n_checks++;
        if (rsp_q.size() > 0 && rsp_q[0] !== {4'hE, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: {res,c,z}=%h/%b/%b, required e/1/0",
                     rsp_q[0][5:2], rsp_q[0][1], rsp_q[0][0]);
        end
        n_checks++;
        if (rsp_q.size() > 1 && rsp_q[1] !== {4'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL not_f: {res,c,z}=%h/%b/%b, required 0/1/1",
                     rsp_q[1][5:2], rsp_q[1][1], rsp_q[1][0]);
        end
    endtask

    task automatic test_backpressure();
        idle_clear();
        bus.rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_one(4'(i), 4'h1, 3'b000, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
            bus.rsp_result !== 4'h2) begin
            n_fail++;
            $display("FAIL bp_full: cnt=%0d rdy=%b v=%b r=%h, required 4 0 1 2",
                     bus.fifo_count, bus.cmd_ready, bus.rsp_valid, bus.rsp_result);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (bus.alu_a !== 4'h2 || bus.alu_b !== 4'h1 || bus.alu_sel !== 3'b000 ||
                bus.rsp_result !== 4'h2 || bus.fifo_count !== 3'd4) begin
                n_fail++;
                $display("FAIL bp_stall: a=%h b=%h sel=%0d r=%h cnt=%0d, required 2 1 0 2 4",
                         bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_result, bus.fifo_count);
            end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_rsp(5, "bp");
        for (int i = 0; i < 5 && i < rsp_q.size(); i++) begin
            n_checks++;
            if (rsp_q[i][5:2] !== 4'(i + 2) || (i > 0 && rsp_cyc_q[i] != rsp_cyc_q[i-1] + 1)) begin
                n_fail++;
                $display("FAIL bp_rsp%0d: result=%h cycle_gap=%0d, required %h 1", i,
                         rsp_q[i][5:2], (i > 0) ? rsp_cyc_q[i] - rsp_cyc_q[i-1] : 1, 4'(i + 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        idle_clear();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(4'(i), 4'h3, 3'b000, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd2) begin
            n_fail++; $display("FAIL b2b_prefill: count=%0d, required 2", bus.fifo_count);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.cmd_a = 4'(k + 3); bus.cmd_b = 4'h3; bus.cmd_sel = 3'b000; bus.cmd_use_acc = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bus.fifo_count !== 3'd2 || bus.cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_count%0d: count=%0d rdy=%b, required 2 1", k,
                         bus.fifo_count, bus.cmd_ready);
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd2) begin
            n_fail++; $display("FAIL b2b_after: count=%0d, required 2", bus.fifo_count);
        end
        wait_rsp(11, "b2b");
        for (int i = 0; i < 11 && i < rsp_q.size(); i++) begin
            n_checks++;
            if (rsp_q[i] !== {4'(i + 3), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_rsp%0d: {res,c,z}=%h/%b/%b, required %h/0/0", i,
                         rsp_q[i][5:2], rsp_q[i][1], rsp_q[i][0], 4'(i + 3));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        test_reset();
        test_single_add();
        test_acc_chain();
        test_flags();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Front-end and back-end stage wrapped around the combinational 4-bit ALU (alu_4bit).
- Buffers incoming ALU commands in a small FIFO.
- Presents the head command to the ALU on alu_a / alu_b / alu_sel.
- Registers the ALU's result, carry and zero into a response register with a valid/ready handshake.
- Keeps an accumulator so that chained operations can use the previous result as operand A.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >= 2)
CW, $clog2(DEPTH)+1, width of fifo_count (derived; do not override)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_sel  in  3  ALU opcode (same encoding as alu_4bit)
cmd_use_acc  in  1  1 = replace operand A with the accumulator at issue time
alu_a  out  4  to ALU A
alu_b  out  4  to ALU B
alu_sel  out  3  to ALU sel
alu_result  in  4  from ALU result
alu_carry  in  1  from ALU carry
alu_zero  in  1  from ALU zero
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  consumer accepts the response
rsp_result  out  4  registered result
rsp_carry  out  1  registered carry/borrow bit (ALU bit 4, passed unchanged)
rsp_zero  out  1  registered zero flag
acc  out  4  accumulator value
fifo_count  out  CW  entries currently in the FIFO (0..DEPTH)

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers, fifo_count, rsp_valid, rsp_result, rsp_carry, rsp_zero and acc all go to 0.
  - cmd_ready is 1 once rst_n is high.
  - An in-flight or queued command is discarded. No response is produced for it.
- Push:
  - cmd_ready = (fifo_count < DEPTH). There is no bypass when full.
  - A push occurs on a clock edge when cmd_valid && cmd_ready.
  - Each entry stores {a, b, sel, use_acc}. use_acc is resolved at issue, not at push.
- Issue:
  - head_ok = (fifo_count != 0).
  - out_free = !rsp_valid || rsp_ready.
  - pop = head_ok && out_free.
- ALU drive (combinational from the head entry):
  - alu_a = head.use_acc ? acc : head.a.
  - alu_b = head.b.
  - alu_sel = head.sel.
  - When the FIFO is empty, alu_a, alu_b and alu_sel are all 0.
- On pop (same edge):
  - rsp_result <= alu_result, rsp_carry <= alu_carry, rsp_zero <= alu_zero.
  - rsp_valid <= 1.
  - acc <= alu_result.
  - Read pointer advances.
- When rsp_valid && rsp_ready and there is no pop: rsp_valid <= 0. Data registers hold their value.
- Data registers hold while rsp_valid && !rsp_ready (stall). The ALU drive is held stable on the same head entry.
- Latency and throughput:
  - Command pushed at edge N, with the FIFO empty and out_free, is issued at edge N+1. rsp_valid is high after edge N+1.
  - Sustained throughput is 1 command per cycle when rsp_ready = 1.
- Push and pop on the same edge: fifo_count unchanged. Both pointers wrap modulo DEPTH.
- Back-to-back use_acc: the second command sees the acc updated by the first. There is no hazard, because acc and rsp update on the same edge the next head appears.
- Flags are not reinterpreted. Examples:
  - SUB borrow appears as carry = 1.
  - NOT of 4'hF gives result 0, carry 1, zero 1.
- A response is never dropped or duplicated. Each accepted command produces exactly one rsp handshake, in order.

Test Plan:
- Reset check: assert rst_n low mid-stream with 3 queued commands -> fifo_count=0, rsp_valid=0, acc=0, cmd_ready=1, and none of the 3 responses ever appear.
- Single ADD: a=9, b=8, sel=000, rsp_ready=1 -> one cycle after acceptance rsp_result=1, rsp_carry=1, rsp_zero=0, acc=1.
- Accumulator chain: ADD 3+4, then ADD use_acc b=2, then SUB use_acc b=9 -> results 7, 9, 0 with zero=1, carry=0.
- SUB borrow: a=3, b=5, sel=001 -> rsp_result=E, rsp_carry=1; NOT a=F -> result 0, carry 1, zero 1.
- Backpressure: rsp_ready=0, push 5 commands -> first issues, next 4 fill the FIFO, fifo_count=4, cmd_ready=0, alu_* stable. Then rsp_ready=1 -> 5 responses in order on consecutive cycles.
- Simultaneous push/pop at fifo_count=2 with rsp_ready=1 for 8 cycles -> fifo_count stays 2, pointers wrap, order preserved.
